// File: rtl/asic_ram_arbiter.sv
// Fixed-priority arbiter (video > DMA > CPU) for the single-port ASIC RAM,
// with a CPU starvation guard and a tagged read-return pipeline.
module asic_ram_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int RD_LAT       = 1,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              enable,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_valid,
    output logic [7:0]        vid_q,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic              dma_valid,
    output logic [7:0]        dma_q,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic              cpu_valid,
    output logic [7:0]        cpu_q,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_q
);

    localparam int CNT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam int TAG_D = RD_LAT + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        ID_VID = 2'd0,
        ID_DMA = 2'd1,
        ID_CPU = 2'd2
    } req_id_e;

    typedef struct packed {
        logic    vld;
        req_id_e id;
    } tag_t;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_rd_q, ram_rd_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_din_q, ram_din_d;
    logic              vid_ack_q, dma_ack_q, cpu_ack_q;
    logic [CNT_W-1:0]  cpu_cnt_q, cpu_cnt_d;
    tag_t              tag_q [TAG_D];
    tag_t              tag_d [TAG_D];
    logic              vid_valid_q, vid_valid_d;
    logic              dma_valid_q, dma_valid_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic [7:0]        vid_data_q, vid_data_d;
    logic [7:0]        dma_data_q, dma_data_d;
    logic [7:0]        cpu_data_q, cpu_data_d;

    logic vid_el, dma_el, cpu_el, cpu_force;
    logic gnt_vid, gnt_dma, gnt_cpu;
    tag_t tag_exit;

    // A requester whose ack is currently high is masked, so a held request
    // cannot issue twice and each client gets at most one slot per 2 cycles.
    always_comb begin
        vid_el    = enable & vid_req & ~vid_ack_q;
        dma_el    = enable & dma_req & ~dma_ack_q;
        cpu_el    = enable & cpu_req & ~cpu_ack_q;
        cpu_force = cpu_el && (cpu_cnt_q == CNT_MAX);
        gnt_vid   = 1'b0;
        gnt_dma   = 1'b0;
        gnt_cpu   = 1'b0;
        if (cpu_force)   gnt_cpu = 1'b1;
        else if (vid_el) gnt_vid = 1'b1;
        else if (dma_el) gnt_dma = 1'b1;
        else if (cpu_el) gnt_cpu = 1'b1;
    end

    always_comb begin
        ram_addr_d = ram_addr_q;
        if (gnt_vid)      ram_addr_d = vid_addr;
        else if (gnt_dma) ram_addr_d = dma_addr;
        else if (gnt_cpu) ram_addr_d = cpu_addr;
        ram_rd_d  = gnt_vid | gnt_dma | (gnt_cpu & ~cpu_we);
        ram_wr_d  = gnt_cpu & cpu_we;
        ram_din_d = (gnt_cpu & cpu_we) ? cpu_din : ram_din_q;

        // Counter holds while enable is low because cpu_el is then 0.
        cpu_cnt_d = cpu_cnt_q;
        if (!cpu_req || gnt_cpu)
            cpu_cnt_d = '0;
        else if (cpu_el && (cpu_cnt_q != CNT_MAX))
            cpu_cnt_d = cpu_cnt_q + CNT_W'(1);
    end

    always_comb begin
        tag_d[0].vld = ram_rd_d;
        tag_d[0].id  = gnt_vid ? ID_VID : (gnt_dma ? ID_DMA : ID_CPU);
        for (int i = 1; i < TAG_D; i++)
            tag_d[i] = tag_q[i-1];

        tag_exit    = tag_q[TAG_D-1];
        vid_valid_d = tag_exit.vld && (tag_exit.id == ID_VID);
        dma_valid_d = tag_exit.vld && (tag_exit.id == ID_DMA);
        cpu_valid_d = tag_exit.vld && (tag_exit.id == ID_CPU);
        vid_data_d  = vid_valid_d ? ram_q : vid_data_q;
        dma_data_d  = dma_valid_d ? ram_q : dma_data_q;
        cpu_data_d  = cpu_valid_d ? ram_q : cpu_data_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_din_q   <= '0;
            vid_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_cnt_q   <= '0;
            for (int i = 0; i < TAG_D; i++)
                tag_q[i] <= '0;
            vid_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            vid_data_q  <= '0;
            dma_data_q  <= '0;
            cpu_data_q  <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
            ram_din_q   <= ram_din_d;
            vid_ack_q   <= gnt_vid;
            dma_ack_q   <= gnt_dma;
            cpu_ack_q   <= gnt_cpu;
            cpu_cnt_q   <= cpu_cnt_d;
            for (int i = 0; i < TAG_D; i++)
                tag_q[i] <= tag_d[i];
            vid_valid_q <= vid_valid_d;
            dma_valid_q <= dma_valid_d;
            cpu_valid_q <= cpu_valid_d;
            vid_data_q  <= vid_data_d;
            dma_data_q  <= dma_data_d;
            cpu_data_q  <= cpu_data_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_rd    = ram_rd_q;
    assign ram_wr    = ram_wr_q;
    assign ram_din   = ram_din_q;
    assign vid_ack   = vid_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_valid = vid_valid_q;
    assign dma_valid = dma_valid_q;
    assign cpu_valid = cpu_valid_q;
    assign vid_q     = vid_data_q;
    assign dma_q     = dma_data_q;
    assign cpu_q     = cpu_data_q;
    assign cpu_wait  = cpu_req & ~cpu_ack_q;

endmodule

// File: doc/asic_ram_arbiter.md
# asic_ram_arbiter

Arbitrates the single-port 16 KB ASIC register/sprite RAM between three requesters: the video sprite/palette fetcher, the audio DMA engine, and the CPU window at &4000–&7FFF. It sits between those clients and the ASIC RAM macro, issuing at most one access per clock. Requesters are served in fixed priority, with a starvation guard for the CPU. Read data is routed back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 14, RAM address width.
- RD_LAT, 1, RAM read latency in cycles from ram_rd to valid ram_q (≥1).
- CPU_MAX_WAIT, 4, consecutive lost arbitration edges after which the CPU wins (≥1).

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  grant enable (plus_mode & use_asic); low = issue no new accesses.
- vid_req  in  1  video read request, level, held until ack.
- vid_addr  in  ADDR_W  video read address.
- vid_ack  out  1  one-cycle pulse: video access issued this cycle.
- vid_valid  out  1  one-cycle pulse: vid_q updated.
- vid_q  out  8  video read data, held between valids.
- dma_req, dma_addr, dma_ack, dma_valid, dma_q: same as the video set, for the audio DMA (read only).
- cpu_req  in  1  CPU request, level, held until ack.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  CPU address (window offset).
- cpu_din  in  8  CPU write data.
- cpu_ack, cpu_valid, cpu_q: as for video; cpu_valid is raised for reads only.
- cpu_wait  out  1  cpu_req & ~cpu_ack (combinational); drives the Z80 WAIT.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_rd  out  1  registered RAM read strobe.
- ram_wr  out  1  registered RAM write strobe.
- ram_din  out  8  registered RAM write data.
- ram_q  in  8  RAM read data, valid RD_LAT cycles after ram_rd.

## Operation
- Arbitration happens at every rising edge.
  - Eligible requester: req high, its ack currently low, and enable high.
  - A requester whose ack is high is masked for that edge. This stops a held request from issuing twice and limits each requester to one access per 2 cycles.
- Priority: video > DMA > CPU.
  - Override: if cpu_cnt == CPU_MAX_WAIT and the CPU is eligible, the CPU wins.
- On a winning edge, the block registers:
  - ram_addr = winner addr;
  - ram_rd = 1 for reads; ram_wr = 1 for CPU writes;
  - ram_din = cpu_din on CPU writes, otherwise it holds its previous value;
  - the winner's ack = 1.
- On a non-winning edge, ram_rd, ram_wr and all acks go to 0. ram_addr holds its value.
- cpu_cnt (width clog2(CPU_MAX_WAIT+1), saturating):
  - increments at each edge where the CPU is eligible and does not win;
  - clears to 0 when the CPU wins, or when cpu_req is low.
- Read return path:
  - A tag shift pipeline of depth RD_LAT+1 carries {valid, id ∈ vid/dma/cpu} for each issued read.
  - On tag exit, the named requester's q is loaded from ram_q (registered) and its valid pulses for 1 cycle.
  - CPU writes produce no tag.
- enable low:
  - no new grants; acks drop;
  - in-flight reads still complete and deliver valid;
  - cpu_cnt holds.
- Reset (asynchronous): all outputs 0, cpu_cnt 0, tag pipeline cleared. In-flight reads are discarded, with no valid after release.

## Timing
- Grant latency: req sampled high at edge E with no competitor → ack, ram_* asserted for cycle E..E+1.
- Read data: valid and q appear RD_LAT+1 cycles after the ack cycle. With RD_LAT=1, valid is high in the cycle starting at edge E+2.
- Requester protocol:
  - sees ack=1 at edge E+1;
  - may change addr/we/din at E+1, or drop req;
  - a new request can be granted no earlier than edge E+2.
- Simultaneous video+DMA held continuously: grants alternate video, DMA, video, DMA.
- Starvation bound:
  - With both video and DMA saturating, the CPU is granted at the (CPU_MAX_WAIT+1)th edge after it requests.
  - Maximum CPU wait is CPU_MAX_WAIT+1 cycles to ack.
- Pipeline tags and valids advance regardless of enable.

## Test plan
- CPU write: cpu_req=1, cpu_we=1, addr=&2400, din=&5A at edge 0 → cycle 0–1: cpu_ack=1, ram_wr=1, ram_addr=&2400, ram_din=&5A; no cpu_valid.
- CPU read of &2400, RAM model returning &5A at RD_LAT=1 → cpu_ack cycle 0–1; cpu_valid=1 with cpu_q=&5A in cycle 2–3; cpu_wait high only until ack.
- Video, DMA and CPU all held high from edge 0 (CPU_MAX_WAIT=4), video/DMA re-requesting immediately → ack order vid, dma, vid, dma, cpu on edges 0–4; cpu_cnt=4 at edge 4, then 0.
- Routing: video read &0010 (RAM=&11), then DMA read &0020 (RAM=&22) on consecutive grants → vid_valid/vid_q=&11, then next cycle dma_valid/dma_q=&22; cpu_valid stays 0.
- enable=0 with vid_req held and a read in flight → in-flight valid still arrives; no acks while low; enable=1 → vid_ack on the next edge.
- Reset pulsed one cycle after a video read ack → all outputs 0 asynchronously; no vid_valid after release; a fresh request is granted normally.
